// File: rtl/des_block_packer_if.sv
// Byte-in / block-out bus of the DES block packer, including the key capture lines.
interface des_block_packer_if;
    logic [64:1] key_in;
    logic        key_load;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        byte_ready;
    logic [64:1] blk_m;
    logic [64:1] blk_k;
    logic        blk_valid;
    logic        blk_ready;
    logic        blk_last;

    // Packer side: takes bytes and the key, presents blocks.
    modport slave (
        input  key_in, key_load, byte_in, byte_valid, byte_last, blk_ready,
        output byte_ready, blk_m, blk_k, blk_valid, blk_last
    );

    // Producer/consumer side: supplies bytes and the key, takes blocks.
    modport master (
        output key_in, key_load, byte_in, byte_valid, byte_last, blk_ready,
        input  byte_ready, blk_m, blk_k, blk_valid, blk_last
    );
endinterface

// File: rtl/des_block_packer.sv
// Packs a plaintext byte stream into 64-bit DES blocks, big-endian byte order,
// finishing a message with PKCS#5 padding (PAD_EN=1) or zero fill (PAD_EN=0).
// Each block carries the key that was captured at the start of that block.
module des_block_packer #(
    parameter bit PAD_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    des_block_packer_if.slave   bus
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        PAD    = 2'd1,
        HOLD   = 2'd2,
        PADBLK = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [64:1] blk_m_q;
    logic [64:1] key_q;
    logic        blk_last_q;
    logic        pad_pending;
    logic [7:0]  pad_byte;
    logic        accept;
    logic        handshake;
    logic        wr_en;
    logic [7:0]  wr_byte;

    // byte_ready is gated by rst_n so nothing is offered while reset is held.
    assign bus.byte_ready = rst_n && (state == FILL);
    assign bus.blk_valid  = (state == HOLD) || (state == PADBLK);
    assign bus.blk_m      = blk_m_q;
    assign bus.blk_k      = key_q;
    assign bus.blk_last   = blk_last_q;

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign handshake = bus.blk_valid && bus.blk_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and selection of the byte written into the current slot.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_byte    = bus.byte_in;
        case (state)
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (cnt == 3'd7) begin
                        state_next = HOLD;
                    end else if (bus.byte_last) begin
                        state_next = PAD;
                    end
                end
            end
            PAD: begin
                wr_en   = 1'b1;
                wr_byte = pad_byte;
                if (cnt == 3'd7) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    state_next = pad_pending ? PADBLK : FILL;
                end
            end
            PADBLK: begin
                if (handshake) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Datapath: key capture, byte slot writes, counter, last/pad bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 3'd0;
            blk_m_q     <= '0;
            key_q       <= '0;
            blk_last_q  <= 1'b0;
            pad_pending <= 1'b0;
            pad_byte    <= 8'h00;
        end else begin
            if ((state == FILL) && (cnt == 3'd0) && bus.key_load) begin
                key_q <= bus.key_in;
            end

            if (wr_en) begin
                for (int i = 0; i < 8; i++) begin
                    if (cnt == 3'(i)) begin
                        blk_m_q[64-8*i -: 8] <= wr_byte;
                    end
                end
            end

            case (state)
                FILL: begin
                    if (accept) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            blk_last_q  <= bus.byte_last && !PAD_EN;
                            pad_pending <= bus.byte_last && PAD_EN;
                        end else if (bus.byte_last) begin
                            pad_byte <= PAD_EN ? {5'd0, 3'd7 - cnt} : 8'h00;
                        end
                    end
                end
                PAD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        blk_last_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        if (pad_pending) begin
                            blk_m_q     <= {8{8'h08}};
                            blk_last_q  <= 1'b1;
                            pad_pending <= 1'b0;
                        end else begin
                            blk_last_q <= 1'b0;
                        end
                    end
                end
                PADBLK: begin
                    if (handshake) begin
                        blk_last_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/des_block_packer.md
DES_BLOCK_PACKER -- requirements
Module: des_block_packer

Interface
REQ-001 Parameter PAD_EN, default 1, SHALL select PKCS#5 padding (1) or zero-fill of the final partial block (0).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 key_in  input  [64:1]  SHALL carry the DES key candidate.
REQ-005 key_load  input  1  SHALL request capture of key_in.
REQ-006 byte_in  input  [7:0]  SHALL carry the plaintext byte.
REQ-007 byte_valid  input  1  SHALL mark byte_in as valid.
REQ-008 byte_last  input  1  SHALL mark the final message byte; it is qualified by byte_valid.
REQ-009 byte_ready  output  1  SHALL indicate that a byte can be accepted this cycle.
REQ-010 blk_m  output  [64:1]  SHALL carry the packed 64-bit block M for the DES encryption stage.
REQ-011 blk_k  output  [64:1]  SHALL carry the key bound to blk_m.
REQ-012 blk_valid  output  1  SHALL mark blk_m/blk_k/blk_last as valid.
REQ-013 blk_ready  input  1  SHALL indicate that the downstream stage takes the block.
REQ-014 blk_last  output  1  SHALL mark the final block of a message.

Function
REQ-015 The block SHALL implement the states FILL, PAD, HOLD and PADBLK with a 3-bit byte counter cnt (0..7).
REQ-016 A byte SHALL be accepted only when byte_valid and byte_ready are both 1; byte_ready SHALL be 1 in FILL only.
REQ-017 Accepted byte number n (0-based) SHALL be written to blk_m[64-8n:57-8n]; the first byte occupies blk_m[64:57].
REQ-018 On acceptance with cnt=7 and byte_last=0, the block SHALL go to HOLD with blk_last=0 and cnt SHALL wrap to 0.
REQ-019 On acceptance of a byte_last with cnt=k<7 and PAD_EN=1, the block SHALL go to PAD and write the pad byte (7-k) into bytes k+1..7, one byte per cycle, then go to HOLD with blk_last=1.
REQ-020 With PAD_EN=0 and byte_last at cnt<7, the remaining bytes SHALL be 0x00, written in the same PAD sequence, with blk_last=1.
REQ-021 On acceptance of byte_last with cnt=7 and PAD_EN=1, the block SHALL emit the data block with blk_last=0 and then enter PADBLK.
REQ-022 In PADBLK, the block SHALL present the block 0x0808080808080808 with blk_last=1 and the same key.
REQ-023 On acceptance of byte_last with cnt=7 and PAD_EN=0, the data block SHALL be emitted with blk_last=1.
REQ-024 In HOLD and PADBLK, blk_valid SHALL be 1, and blk_m, blk_k and blk_last SHALL be stable until the cycle in which blk_ready=1.
REQ-025 After a handshake, the next state SHALL be PADBLK if a full pad block is pending, otherwise FILL with cnt=0; blk_valid SHALL fall in the following cycle.
REQ-026 key_load SHALL update the key register only in FILL with cnt=0; at all other times it SHALL be ignored.
REQ-027 If key_load and an accepted byte coincide at cnt=0, the new key SHALL be bound to that block.
REQ-028 blk_k SHALL be the key register; the key SHALL remain fixed from the first byte of a block until that block's handshake.
REQ-029 byte_valid without byte_ready SHALL have no effect; byte_last without byte_valid SHALL be ignored.
REQ-030 Latency SHALL be as follows: blk_valid rises the cycle after the 8th byte is accepted, or (8-k-1) PAD cycles later for a partial block.

Reset
REQ-031 While rst_n=0, the block SHALL hold state FILL, cnt=0, blk_m=0, key=0, blk_valid=0, blk_last=0 and byte_ready=0.
REQ-032 byte_ready SHALL become 1 in the first cycle after rst_n deasserts.
REQ-033 A reset asserted mid-fill, mid-PAD or in HOLD SHALL discard the partial or pending block immediately and deassert blk_valid.

Verification
REQ-034 Scenario 1: load key 0x133457799BBCDFF1, then send bytes 01..08 with no last, blk_ready=1 -> blk_m=0x0102030405060708, blk_k=0x133457799BBCDFF1, blk_last=0.
REQ-035 Scenario 2: PAD_EN=1, send bytes AA BB CC with last on CC -> 5 PAD cycles, then blk_m=0xAABBCC0505050505, blk_last=1.
REQ-036 Scenario 3: PAD_EN=1, send 8 bytes 11..88 with last on the 8th -> first block 0x1122334455667788 with blk_last=0, second block 0x0808080808080808 with blk_last=1.
REQ-037 Scenario 4: hold blk_ready=0 for 4 cycles in HOLD while key_load and byte_valid are asserted -> outputs stable, byte_ready=0, key unchanged; on handshake, FILL resumes.
REQ-038 Scenario 5: assert rst_n=0 after 3 bytes, release, then send 8 bytes 01..08 -> blk_m=0x0102030405060708 with no stale data and key=0.
REQ-039 Scenario 6: PAD_EN=0, send one byte 5A with last -> blk_m=0x5A00000000000000, blk_last=1.
